bnn_weight_streamer: RTL and testbench

Host-side driver for the BNN neuron weight-load interface. Holds a shadow table of NUM_NEURONS x NUM_WEIGHTS weights and, on a start request, emits one full reload burst on the load_en / weight bus. Each beat carries one neuron's weights. The block keeps a pointer mirror of the receiver's wrap-around neuron counter, so beats always land on the intended neuron.

---
 rtl/bnn_pkg.sv | 32 +++
 rtl/bnn_weight_table.sv | 29 ++
 rtl/bnn_weight_streamer.sv | 158 +++++++++++++++
 tb/tb_bnn_weight_streamer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared sizes, weight type, power-up weight image and FSM state type for the BNN weight streamer.
// GAP_CYCLES only takes effect in builds with BNN_STREAM_GAP_EN defined.
package bnn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int NUM_WEIGHTS = 6;
    localparam int PTR_W       = 2;
    localparam int CNT_W       = PTR_W + 1;
    localparam int GAP_CYCLES  = 1;

    typedef logic [NUM_WEIGHTS-1:0] weight_t;

    // Must match the receiver's own power-up weights so an unloaded receiver agrees with the table.
    localparam weight_t DEFAULT_IMAGE [NUM_NEURONS] = '{
        6'b111000,
        6'b000111,
        6'b001100,
        6'b110011
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/bnn_weight_table.sv
// Shadow table of NUM_NEURONS weight words: synchronous write, combinational read.
// Reset reloads the receiver's power-up image.
module bnn_weight_table
    import bnn_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   wr_en_i,
    input  logic [PTR_W-1:0]       wr_addr_i,
    input  logic [NUM_WEIGHTS-1:0] wr_data_i,
    input  logic [PTR_W-1:0]       rd_addr_i,
    output logic [NUM_WEIGHTS-1:0] rd_data_o
);

    weight_t mem_q [NUM_NEURONS];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_q[i] <= DEFAULT_IMAGE[i];
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/bnn_weight_streamer.sv
// Emits one NUM_NEURONS-beat weight reload burst per accepted start, keeping ptr aligned with the receiver.
// Define BNN_STREAM_GAP_EN to insert GAP_CYCLES idle cycles between beats.
//
// state    | meaning
// S_IDLE   | table writable, waiting for start
// S_STREAM | one beat on the bus this cycle
// S_GAP    | idle spacing between beats (gap builds only)
// S_DONE   | one-cycle done pulse, bus idle
module bnn_weight_streamer
    import bnn_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   wr_en_i,
    input  logic [PTR_W-1:0]       wr_addr_i,
    input  logic [NUM_WEIGHTS-1:0] wr_data_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   load_en_o,
    output logic [NUM_WEIGHTS-1:0] weight_out_o,
    output logic [PTR_W-1:0]       ptr_o,
    output logic                   wr_drop_o
);

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               load_en_q;
    logic               wr_drop_q;
    weight_t            weight_q;

`ifdef BNN_STREAM_GAP_EN
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    logic [GAP_W-1:0]   gap_cnt_q;
`endif

    logic               tbl_we;
    logic [PTR_W-1:0]   rd_addr_d;
    weight_t            rd_data;
    weight_t            beat_weight_d;
    logic               last_beat;

    assign tbl_we    = wr_en_i && (state_q == S_IDLE);
    assign last_beat = (beat_cnt_q == CNT_W'(NUM_NEURONS));

    bnn_weight_table u_table (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (tbl_we),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (rd_data)
    );

    // The next beat's word: while streaming it is the following neuron; a write landing on the
    // same edge as start is forwarded so the burst carries it.
    always_comb begin
        rd_addr_d = ptr_q;
        if (state_q == S_STREAM) begin
            rd_addr_d = ptr_next(ptr_q);
        end
        beat_weight_d = rd_data;
        if (tbl_we && (wr_addr_i == rd_addr_d)) begin
            beat_weight_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_en_q  <= 1'b0;
            weight_q   <= '0;
            wr_drop_q  <= 1'b0;
`ifdef BNN_STREAM_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            if (wr_en_i && (state_q != S_IDLE)) begin
                wr_drop_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q    <= S_STREAM;
                        beat_cnt_q <= CNT_W'(1);
                        busy_q     <= 1'b1;
                        load_en_q  <= 1'b1;
                        weight_q   <= beat_weight_d;
                        wr_drop_q  <= 1'b0;
                    end
                end

                S_STREAM: begin
                    ptr_q <= ptr_next(ptr_q);
                    if (last_beat) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        load_en_q <= 1'b0;
                        weight_q  <= '0;
`ifdef BNN_STREAM_GAP_EN
                    end else if (GAP_CYCLES != 0) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= GAP_W'(GAP_LOAD);
                        load_en_q <= 1'b0;
                        weight_q  <= '0;
`endif
                    end else begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        load_en_q  <= 1'b1;
                        weight_q   <= beat_weight_d;
                    end
                end

`ifdef BNN_STREAM_GAP_EN
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q    <= S_STREAM;
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        load_en_q  <= 1'b1;
                        weight_q   <= beat_weight_d;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
`endif

                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign load_en_o    = load_en_q;
    assign weight_out_o = weight_q;
    assign ptr_o        = ptr_q;
    assign wr_drop_o    = wr_drop_q;

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Self-checking bench for bnn_weight_streamer: a burst-timing model plus a receiver model,
// compared every cycle, with literal checks pinning key beats.
module tb_bnn_weight_streamer;
    import bnn_pkg::*;

    localparam int N = 4;
`ifdef BNN_STREAM_GAP_EN
    localparam int G = GAP_CYCLES;
`else
    localparam int G = 0;
`endif
    localparam int LAST = N + (N - 1) * G;

    logic       clk = 1'b0;
    logic       reset, wr_en, start;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic       busy, done, load_en, wr_drop;
    logic [5:0] weight_out;
    logic [1:0] ptr;

    int n_cmp = 0;
    int n_err = 0;

    // model state after the most recent rising edge
    logic [5:0] tbl [N];
    logic [5:0] rx_w [N];
    int         rx_cnt;
    bit         active;
    int         e;
    int         p0;
    int         mptr;
    bit         drop;

    always #5 clk = ~clk;

    bnn_weight_streamer dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .load_en_o    (load_en),
        .weight_out_o (weight_out),
        .ptr_o        (ptr),
        .wr_drop_o    (wr_drop)
    );

    task automatic model_reset();
        tbl[0] = 6'b111000;
        tbl[1] = 6'b000111;
        tbl[2] = 6'b001100;
        tbl[3] = 6'b110011;
        active = 1'b0;
        e      = 0;
        p0     = 0;
        mptr   = 0;
        drop   = 1'b0;
        rx_cnt = 0;
    endtask

    // compare then advance the model with the inputs the next rising edge will sample
    initial begin
        logic       eb, ed, el;
        logic [5:0] ew;
        logic [1:0] ep;
        int         j;
        model_reset();
        forever begin
            @(negedge clk);
            eb = 1'b0; ed = 1'b0; el = 1'b0; ew = '0; ep = 2'(mptr);
            if (active) begin
                if (e <= LAST) begin
                    j  = (e - 1) / (G + 1);
                    eb = 1'b1;
                    if ((e - 1) % (G + 1) == 0) begin
                        el = 1'b1;
                        ep = 2'((p0 + j) % N);
                        ew = tbl[ep];
                    end else begin
                        ep = 2'((p0 + j + 1) % N);
                    end
                end else begin
                    ed = 1'b1;
                    ep = 2'(p0);
                end
            end
            n_cmp++;
            if ({busy, done, load_en, weight_out, ptr, wr_drop} !== {eb, ed, el, ew, ep, drop}) begin
                n_err++;
                $display("FAIL cycle@%0t outputs: got busy=%b done=%b load_en=%b w=%b ptr=%0d drop=%b, need busy=%b done=%b load_en=%b w=%b ptr=%0d drop=%b",
                         $time, busy, done, load_en, weight_out, ptr, wr_drop, eb, ed, el, ew, ep, drop);
            end
            if (load_en === 1'b1) begin
                rx_w[rx_cnt] = weight_out;
                rx_cnt = (rx_cnt + 1) % N;
            end

            if (reset) begin
                model_reset();
            end else if (!active) begin
                if (wr_en) tbl[wr_addr] = wr_data;
                if (start) begin
                    active = 1'b1;
                    e      = 1;
                    p0     = mptr;
                    drop   = 1'b0;
                end
            end else begin
                if (wr_en) drop = 1'b1;
                if (e == LAST + 1) begin
                    active = 1'b0;
                    e      = 0;
                end else begin
                    e++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) return;
            tick();
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no done pulse required done within 100 cycles", name);
    endtask

    task automatic rx_check(input string name);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s rx_w[%0d]", name, k), int'(rx_w[k]), int'(tbl[k]));
        end
    endtask

    initial begin
        int beats, dones;
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst load_en", load_en, 0);
        check("rst weight", weight_out, 0);
        check("rst ptr", ptr, 0);
        check("rst wr_drop", wr_drop, 0);
        reset = 1'b0;
        tick();

        // default image burst
        start = 1'b1; tick(); start = 1'b0;
        check("t1 b0 load_en", load_en, 1);
        check("t1 b0 w", weight_out, 6'b111000);
        check("t1 b0 ptr", ptr, 0);
        repeat (G + 1) tick();
        check("t1 b1 w", weight_out, 6'b000111);
        check("t1 b1 ptr", ptr, 1);
        repeat (G + 1) tick();
        check("t1 b2 w", weight_out, 6'b001100);
        check("t1 b2 ptr", ptr, 2);
        repeat (G + 1) tick();
        check("t1 b3 w", weight_out, 6'b110011);
        check("t1 b3 ptr", ptr, 3);
        tick();
        check("t1 done", done, 1);
        check("t1 done ptr", ptr, 0);
        check("t1 done busy", busy, 0);
        tick();
        rx_check("t1");

        // host writes, second one together with start
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 6'b101010; tick();
        wr_addr = 2'd0; wr_data = 6'b010101; start = 1'b1; tick();
        wr_en = 1'b0; start = 1'b0;
        check("t2 b0 w", weight_out, 6'b010101);
        repeat (2 * (G + 1)) tick();
        check("t2 b2 w", weight_out, 6'b101010);
        wait_done("t2");
        tick();
        rx_check("t2");
        check("t2 rx0 literal", rx_w[0], 6'b010101);
        check("t2 rx2 literal", rx_w[2], 6'b101010);

        // write during burst is dropped
        start = 1'b1; tick(); start = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 6'b111111; tick(); wr_en = 1'b0;
        check("t3 drop set", wr_drop, 1);
        wait_done("t3a");
        tick();
        check("t3 drop sticky", wr_drop, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("t3 drop cleared", wr_drop, 0);
        repeat (G + 1) tick();
        check("t3 b1 old w", weight_out, 6'b000111);
        wait_done("t3b");
        tick();
        rx_check("t3");

        // start held through busy and done: exactly one burst
        beats = 0; dones = 0;
        start = 1'b1;
        for (int i = 0; i < LAST + 2; i++) begin
            tick();
            if (load_en === 1'b1) beats++;
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load_en === 1'b1) beats++;
            if (done === 1'b1) dones++;
        end
        check("t4 beats", beats, N);
        check("t4 dones", dones, 1);

        // reset mid-burst
        start = 1'b1; tick(); start = 1'b0;
        repeat (G + 1) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("t5 rst load_en", load_en, 0);
        check("t5 rst weight", weight_out, 0);
        check("t5 rst ptr", ptr, 0);
        check("t5 rst busy", busy, 0);
        start = 1'b1; tick(); start = 1'b0;
        check("t5 b0 w", weight_out, 6'b111000);
        repeat (2 * (G + 1)) tick();
        check("t5 b2 w", weight_out, 6'b001100);
        wait_done("t5");
        tick();
        rx_check("t5");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
